// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches from a combinational instruction
// memory and buffers {pc, instr} in a small prefetch FIFO for decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned MEM_SIZE_BYTES = 1024,
    parameter int unsigned FIFO_DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic [31:0]                   fetch_pc,
    input  logic [31:0]                   fetch_instr,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_pc,
    output logic [31:0]                   out_instr,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0] PC_MASK = 32'(MEM_SIZE_BYTES - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_mem_q    [FIFO_DEPTH];
    logic [31:0]   pc_mem_d    [FIFO_DEPTH];
    logic [31:0]   instr_mem_q [FIFO_DEPTH];
    logic [31:0]   instr_mem_d [FIFO_DEPTH];
    logic          push;
    logic          pop;

    always_comb begin
        pop         = (count_q != '0) & out_ready;
        push        = ~redirect_valid & ((count_q < DEPTH_C) | pop);
        pc_d        = pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;

        if (redirect_valid) begin
            // Redirect wins over everything; a same-cycle pop is already consumed.
            pc_d     = redirect_pc & PC_MASK & ~32'd3;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]    = pc_q;
                instr_mem_d[wr_ptr_q] = fetch_instr;
                wr_ptr_d              = wr_ptr_q + PW'(1);
                pc_d                  = (pc_q + 32'd4) & PC_MASK;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
    end

    always_comb begin
        fetch_pc  = pc_q;
        occupancy = count_q;
        out_valid = (count_q != '0);
        out_pc    = out_valid ? pc_mem_q[rd_ptr_q] : '0;
        out_instr = out_valid ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the instruction memory and downstream of nothing but the branch/jump resolution logic. It owns the program counter, drives the byte address into the combinational instruction memory, captures the returned 32-bit word with its PC into a small prefetch FIFO, and presents {pc, instruction} to decode over a valid/ready handshake. Redirects from execute flush the FIFO and restart fetch at the target.

Parameters:
RESET_PC, 32'h0000_0000, byte address fetched first after reset; must be 4-byte aligned
MEM_SIZE_BYTES, 1024, instruction memory size in bytes; power of two; PC wraps modulo this value
FIFO_DEPTH, 2, prefetch entries; power of two, >= 2
NOP_INSTR, 32'h0000_0013, value driven on out_instr when FIFO is empty (ADDI x0,x0,0)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset
fetch_pc  output  32  byte address to instruction memory PC input (combinational from PC register)
fetch_instr  input  32  Instruction_Code returned combinationally by instruction memory for fetch_pc
redirect_valid  input  1  one-cycle pulse: discard prefetched work, resume at redirect_pc
redirect_pc  input  32  redirect target byte address
out_valid  output  1  FIFO head holds a valid instruction
out_ready  input  1  decode accepts head this cycle
out_pc  output  32  PC of head instruction
out_instr  output  32  head instruction word
occupancy  output  $clog2(FIFO_DEPTH)+1  entries currently held

Behaviour:
- Reset (reset==0 at clk edge): PC <= RESET_PC; FIFO empty; rd/wr pointers 0. Outputs during and after reset until first push: out_valid=0, out_pc=0, out_instr=NOP_INSTR, occupancy=0, fetch_pc=RESET_PC. Reset mid-operation discards all entries identically.
- fetch_pc = PC register, no added logic; PC[1:0] always 00.
- pop = out_valid & out_ready. push = ~redirect_valid & (occupancy < FIFO_DEPTH | pop).
- On push: write {PC, fetch_instr} at wr pointer; PC <= (PC + 4) mod MEM_SIZE_BYTES (PC at MEM_SIZE_BYTES-4 wraps to 0).
- Full FIFO with pop in same cycle: push still occurs; occupancy unchanged.
- Full FIFO without pop: no push, PC holds, fetch_pc stable.
- Empty FIFO: out_valid=0, out_instr=NOP_INSTR, out_pc=0; out_ready ignored.
- Latency: word fetched in cycle N is visible at head in cycle N+1 (registered FIFO, no bypass). After reset deasserts, out_valid rises one cycle later with out_pc=RESET_PC.
- Throughput: one instruction per cycle sustained with out_ready held high.
- Redirect (highest priority): FIFO flushed (occupancy <= 0, pointers reset); PC <= {redirect_pc[31:2],2'b00} mod MEM_SIZE_BYTES; no push that cycle. Low two target bits silently cleared. A pop in the same cycle is a completed transfer (decode consumed it) and is then flushed along with the remainder. out_valid=0 the cycle after redirect; target instruction appears at head two cycles after the redirect cycle.
- Back-to-back redirects: each restarts; last one wins.
- Head outputs held stable while out_valid=1 and out_ready=0.
- occupancy = entries held; never exceeds FIFO_DEPTH.

Test Plan:
- Reset with memory holding NOPs, RESET_PC=0, out_ready=1 -> first out_valid cycle after release shows out_pc=0, out_instr=0x00000013; then out_pc 4, 8, 12 on consecutive cycles.
- out_ready=0 for 5 cycles after reset -> occupancy reaches 2 and holds, fetch_pc frozen at 8, out_pc stays 0; release ready -> out_pc 0,4,8,12 with no gaps or duplicates.
- Redirect pulse redirect_pc=0x100 while FIFO full, out_ready=1 -> next cycle out_valid=0, occupancy=0, fetch_pc=0x100; following cycle out_pc=0x100.
- redirect_pc=0x0000_0203 -> fetch resumes at 0x200; no out_pc with nonzero low bits ever appears.
- Free-run from PC=0x3F8 with MEM_SIZE_BYTES=1024 -> out_pc sequence 0x3F8, 0x3FC, 0x000, 0x004.
- Assert reset for one cycle while occupancy=2 -> out_valid=0, out_instr=0x00000013, fetch_pc=RESET_PC next cycle; restart sequence matches first scenario.
